// File: rtl/stack_top_display.sv
// Display stage: sequential double-dabble of an 8-bit stack top into three BCD digits
// driving seven-segment outputs, with an "Err" override and a one-entry pending request.
module stack_top_display #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] value_in,
  input  logic       err,
  output logic       busy,
  output logic       done,
  output logic [6:0] Digit0,
  output logic [6:0] Digit1,
  output logic [6:0] Digit2
);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  state_t      state, state_d;
  logic [7:0]  bin_q;
  logic [11:0] bcd_acc;
  logic [11:0] bcd_q;
  logic [2:0]  cnt;
  logic [7:0]  pend_q;
  logic        pend_v;
  logic        err_q;

  logic        do_start;
  logic [7:0]  start_val;
  logic        pend_wr;
  logic        pend_clr;
  logic        commit;
  logic [11:0] adj;
  logic [19:0] shifted;
  logic [6:0]  raw2, raw1, raw0;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // UPDATE both commits the finished result and may immediately start the next one.
  always_comb begin
    state_d   = state;
    do_start  = 1'b0;
    start_val = value_in;
    pend_wr   = 1'b0;
    pend_clr  = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          do_start = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        pend_wr = load;
        if (cnt == 3'd7) state_d = UPDATE;
      end
      UPDATE: begin
        commit = 1'b1;
        if (pend_v) begin
          do_start  = 1'b1;
          start_val = pend_q;
          state_d   = SHIFT;
          pend_wr   = load;
          pend_clr  = !load;
        end else if (load) begin
          do_start = 1'b1;
          state_d  = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    adj     = {add3(bcd_acc[11:8]), add3(bcd_acc[7:4]), add3(bcd_acc[3:0])};
    shifted = {adj, bin_q} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q   <= '0;
      bcd_acc <= '0;
      bcd_q   <= '0;
      cnt     <= '0;
      pend_q  <= '0;
      pend_v  <= 1'b0;
      err_q   <= 1'b0;
      done    <= 1'b0;
    end else begin
      err_q <= err;
      done  <= commit;
      if (commit) bcd_q <= bcd_acc;
      if (do_start) begin
        bin_q   <= start_val;
        bcd_acc <= '0;
        cnt     <= '0;
      end else if (state == SHIFT) begin
        bcd_acc <= shifted[19:8];
        bin_q   <= shifted[7:0];
        cnt     <= cnt + 3'd1;
      end
      if (pend_wr) begin
        pend_q <= value_in;
        pend_v <= 1'b1;
      end else if (pend_clr) begin
        pend_v <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    raw2 = seg_of(bcd_q[11:8]);
    raw1 = seg_of(bcd_q[7:4]);
    raw0 = seg_of(bcd_q[3:0]);
    if (BLANK_LZ) begin
      if (bcd_q[11:8] == 4'd0) raw2 = SEG_BLANK;
      if (bcd_q[11:4] == 8'd0) raw1 = SEG_BLANK;
    end
    if (err_q) begin
      raw2 = SEG_E;
      raw1 = SEG_R;
      raw0 = SEG_R;
    end
  end

  assign Digit2 = ACTIVE_LOW ? raw2 : ~raw2;
  assign Digit1 = ACTIVE_LOW ? raw1 : ~raw1;
  assign Digit0 = ACTIVE_LOW ? raw0 : ~raw0;

endmodule
